dmem_wait_ctrl: RTL and testbench

Parametrised successor data memory for the multi-cycle datapath. It adds byte-addressed word access, per-byte write enables and a programmable wait-state latency. It uses a req/ack handshake, so the control FSM stalls until the access completes, and it flags misaligned accesses. It sits between the datapath's memory-address/MDR registers and the main control unit.

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_wait_ctrl_if.sv | 17 +
 rtl/dmem_bank.sv | 29 ++
 rtl/dmem_wait_ctrl.sv | 103 ++++++++++
 tb/tb_dmem_wait_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, wait-counter width and lane-offset helper for dmem_wait_ctrl.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int CNT_W = 4;
    function automatic int lsb_of(int data_w);
        return $clog2(data_w / 8);
    endfunction
endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// dmem_wait_ctrl_if: req/ack memory access bus between datapath (master) and dmem_wait_ctrl (slave).
interface dmem_wait_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;
    modport master (output req, we, addr, wdata, be, input rdata, ack, busy, err);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack, busy, err);
endinterface

// File: rtl/dmem_bank.sv
// dmem_bank: DEPTH x DATA_W storage, byte-enabled sync write, sync read, word i holds i at time 0.
module dmem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] q
);
    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
        return m;
    endfunction
    // Storage is not reset; its power-up contents come from the declaration.
    mem_t mem = init_mem();
    always_ff @(posedge clk) begin
        for (int k = 0; k < BE_W; k++)
            if (we && be[k]) mem[widx][k*8 +: 8] <= wdata[k*8 +: 8];
        q <= mem[ridx];
    end
endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: multi-cycle data memory with req/ack handshake, wait states and misalign error.
// Optional DMEM_BOUNDS_CHECK_EN: out-of-range byte addresses error like misaligned ones.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH = 1024,
    parameter int ADDR_W = 32,
    parameter int WAIT_CYCLES = 1
) (
    input logic clk,
    input logic rst,
    dmem_wait_ctrl_if.slave bus
);
    localparam int LSB = lsb_of(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W = DATA_W / 8;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [BE_W-1:0]   cap_be;
    logic              bad;
    logic              wen;
    logic [IDX_W-1:0]  ridx;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] rdata;
    logic              ack, busy, err;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign bad = (|cap_addr[LSB-1:0]) || (64'(cap_addr) >= 64'(DEPTH) * 64'(BE_W));
`else
    logic unused_hi;
    assign unused_hi = ^cap_addr[ADDR_W-1:LSB+IDX_W];
    assign bad = |cap_addr[LSB-1:0];
`endif

    // Write commits on the edge leaving RESP; an rst on that same edge suppresses it.
    assign wen = state == RESP && cap_we && !bad && !rst;
    // Read the incoming address while idle so data is ready even with zero wait states.
    assign ridx = state == IDLE ? bus.addr[LSB +: IDX_W] : cap_addr[LSB +: IDX_W];

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            IDLE: if (bus.req) begin
                state_nx = WAIT_CYCLES > 0 ? WAIT : RESP;
                cnt_nx = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
            end
            WAIT: begin
                state_nx = cnt == '0 ? RESP : WAIT;
                cnt_nx = cnt == '0 ? cnt : cnt - 1'b1;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            rdata <= '0;
            ack <= 1'b0;
            busy <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            ack <= state == RESP;
            err <= state == RESP && bad;
            busy <= state_nx != IDLE;
            if (state == RESP && !cap_we && !bad) rdata <= q;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req) begin
            cap_we <= bus.we;
            cap_addr <= bus.addr;
            cap_wdata <= bus.wdata;
            cap_be <= bus.be;
        end
    end

    dmem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
        .clk(clk),
        .we(wen),
        .widx(cap_addr[LSB +: IDX_W]),
        .wdata(cap_wdata),
        .be(cap_be),
        .ridx(ridx),
        .q(q)
    );

    assign bus.rdata = rdata;
    assign bus.ack = ack;
    assign bus.busy = busy;
    assign bus.err = err;
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: three instances (0, 1, 3 wait states) checked against a word-array reference model.
module tb_dmem_wait_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        req_a [3];
    logic        we_a [3];
    logic [31:0] addr_a [3];
    logic [31:0] wdata_a [3];
    logic [3:0]  be_a [3];
    logic [31:0] rdata_a [3];
    logic        ack_a [3];
    logic        busy_a [3];
    logic        err_a [3];

    int total = 0;
    int bad = 0;
    logic [31:0] mem_m [3][1024];
    logic [31:0] last_r [3];

    for (genvar g = 0; g < 3; g++) begin : gu
        localparam int W = g == 0 ? 0 : (g == 1 ? 1 : 3);
        dmem_wait_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b ();
        assign b.req = req_a[g];
        assign b.we = we_a[g];
        assign b.addr = addr_a[g];
        assign b.wdata = wdata_a[g];
        assign b.be = be_a[g];
        assign rdata_a[g] = b.rdata;
        assign ack_a[g] = b.ack;
        assign busy_a[g] = b.busy;
        assign err_a[g] = b.err;
        dmem_wait_ctrl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .WAIT_CYCLES(W)) dut (
            .clk(clk),
            .rst(rst),
            .bus(b)
        );
    end

    function automatic int wc(int u);
        return u == 0 ? 0 : (u == 1 ? 1 : 3);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full access: expected latency, busy, err and rdata come from the model's rules.
    task automatic access(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] bev, input string tag);
        int n;
        int idx;
        logic bad_e;
        logic busy_ok;
        bad_e = a[1:0] != 2'b00;
`ifdef DMEM_BOUNDS_CHECK_EN
        bad_e = bad_e || a >= 32'd4096;
`endif
        idx = int'(a[11:2]);
        @(negedge clk);
        we_a[u] = w; addr_a[u] = a; wdata_a[u] = d; be_a[u] = bev; req_a[u] = 1'b1;
        @(negedge clk);
        req_a[u] = 1'b0; we_a[u] = 1'($urandom); addr_a[u] = $urandom; wdata_a[u] = $urandom; be_a[u] = 4'($urandom);
        n = 1;
        busy_ok = 1'b1;
        while (!ack_a[u] && n < 40) begin
            busy_ok &= busy_a[u];
            @(negedge clk);
            n++;
        end
        if (!bad_e && w)
            for (int k = 0; k < 4; k++) if (bev[k]) mem_m[u][idx][8*k +: 8] = d[8*k +: 8];
        if (!bad_e && !w) last_r[u] = mem_m[u][idx];
        check({tag, "_lat"}, 64'(n), 64'(wc(u) + 2));
        check({tag, "_busy_in"}, 64'(busy_ok), 64'(1));
        check({tag, "_err"}, 64'(err_a[u]), 64'(bad_e));
        check({tag, "_rdata"}, 64'(rdata_a[u]), 64'(last_r[u]));
        check({tag, "_busy_ack"}, 64'(busy_a[u]), 64'(0));
        @(negedge clk);
        check({tag, "_ack_pulse"}, 64'(ack_a[u]), 64'(0));
    endtask

    initial begin
        int seen;
        logic [31:0] a;
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            req_a[u] = 1'b0; we_a[u] = 1'b0; addr_a[u] = '0; wdata_a[u] = '0; be_a[u] = '0;
            last_r[u] = '0;
            for (int i = 0; i < 1024; i++) mem_m[u][i] = 32'(i);
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("rst_ack", 64'(ack_a[u]), 64'(0));
            check("rst_busy", 64'(busy_a[u]), 64'(0));
            check("rst_err", 64'(err_a[u]), 64'(0));
            check("rst_rdata", 64'(rdata_a[u]), 64'(0));
        end
        rst = 1'b0;

        // Back-to-back reads on the zero-wait instance, req held high throughout.
        @(negedge clk);
        req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 32'h0; be_a[0] = '0;
        @(negedge clk);
        check("b2b_c1_ack", 64'(ack_a[0]), 64'(0));
        check("b2b_c1_busy", 64'(busy_a[0]), 64'(1));
        addr_a[0] = 32'h4;
        @(negedge clk);
        check("b2b_ack0", 64'(ack_a[0]), 64'(1));
        check("b2b_rdata0", 64'(rdata_a[0]), 64'(mem_m[0][0]));
        check("b2b_err0", 64'(err_a[0]), 64'(0));
        last_r[0] = mem_m[0][0];
        @(negedge clk);
        check("b2b_c3_ack", 64'(ack_a[0]), 64'(0));
        check("b2b_c3_busy", 64'(busy_a[0]), 64'(1));
        @(negedge clk);
        check("b2b_ack1", 64'(ack_a[0]), 64'(1));
        check("b2b_rdata1", 64'(rdata_a[0]), 64'(mem_m[0][1]));
        last_r[0] = mem_m[0][1];
        req_a[0] = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen += int'(ack_a[0]);
        end
        check("b2b_no_extra_ack", 64'(seen), 64'(0));

        // Directed sequence on the one-wait instance.
        access(1, 1'b0, 32'h10, 32'h0, 4'h0, "rd10");
        check("rd10_val", 64'(rdata_a[1]), 64'h4);
        access(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "wr20");
        access(1, 1'b0, 32'h20, 32'h0, 4'h0, "rd20");
        check("rd20_val", 64'(rdata_a[1]), 64'h00BB00DD);
        access(1, 1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, "wr22_mis");
        check("wr22_err", 64'(err_a[1]), 64'(0));
        access(1, 1'b0, 32'h20, 32'h0, 4'h0, "rd20b");
        check("rd20b_val", 64'(rdata_a[1]), 64'h00BB00DD);
        access(1, 1'b1, 32'h24, 32'h12345678, 4'h0, "wr24_be0");
        access(1, 1'b0, 32'h24, 32'h0, 4'h0, "rd24");
        check("rd24_val", 64'(rdata_a[1]), 64'h9);
        access(1, 1'b0, 32'h1000, 32'h0, 4'h0, "rd1000");
`ifndef DMEM_BOUNDS_CHECK_EN
        check("rd1000_wrap", 64'(rdata_a[1]), 64'h0);
`endif

        // Reset during the second wait cycle of a write on the three-wait instance.
        @(negedge clk);
        req_a[2] = 1'b1; we_a[2] = 1'b1; addr_a[2] = 32'h40; wdata_a[2] = 32'h12345678; be_a[2] = 4'hF;
        @(negedge clk);
        req_a[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy_a[2]), 64'(0));
        check("abort_ack", 64'(ack_a[2]), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 3; u++) last_r[u] = '0;
        check("abort_rdata1", 64'(rdata_a[1]), 64'(0));
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen += int'(ack_a[2]);
        end
        check("abort_no_ack", 64'(seen), 64'(0));
        access(2, 1'b0, 32'h40, 32'h0, 4'h0, "rd40");
        check("rd40_val", 64'(rdata_a[2]), 64'd16);

        // Random mix over a small window, with occasional misalignment and high-bit aliases.
        for (int it = 0; it < 80; it++) begin
            int u;
            u = int'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 15)) * 32'd4;
            if ($urandom_range(0, 4) == 0) a += 32'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) a += 32'h1000 * 32'($urandom_range(1, 3));
            access(u, 1'($urandom), a, $urandom, 4'($urandom), $sformatf("rnd%0d_u%0d", it, u));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
